fixed_addsub_arbiter: RTL and testbench

Shares one `Add_Sub_FixedPoint` instance (Q8.8, 16-bit, N/V/Z flags) between `NUM_REQ` requesters. It sits between the execution-unit issue ports and the shared adder/subtractor. It arbitrates round-robin, registers the granted operands, and registers the result and flags. It returns the response, tagged with the requester index, over a valid/ready channel, with optional saturation on overflow.

---
 rtl/fixed_point_pkg.sv | 29 ++
 rtl/fixed_addsub_arbiter_if.sv | 36 +++
 rtl/Add_Sub_FixedPoint.sv | 28 ++
 rtl/fixed_addsub_arbiter_rr_pick.sv | 37 +++
 rtl/fixed_addsub_arbiter.sv | 150 +++++++++++++++
 tb/tb_fixed_addsub_arbiter.sv | 264 ++++++++++++++++++++++++++
 6 files changed

// File: rtl/fixed_point_pkg.sv
// rtl/fixed_point_pkg.sv - shared Q8.8 types, constants and arbiter FSM states
//   DATA_WIDTH / FRAC_BITS : Q8.8 word geometry
//   fx_t                   : signed fixed-point word
//   fx_flags_t             : {n, v, z} result flags
//   FX_MAX / FX_MIN        : saturation limits
//   arb_state_t            : arbiter FSM states
package fixed_point_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int FRAC_BITS  = 8;

  typedef logic signed [15:0] fx_t;

  typedef struct packed {
    logic n;
    logic v;
    logic z;
  } fx_flags_t;

  localparam fx_t FX_MAX = 16'h7FFF;
  localparam fx_t FX_MIN = 16'h8000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/fixed_addsub_arbiter_if.sv
// rtl/fixed_addsub_arbiter_if.sv - request/response bundle of the shared add/sub arbiter
//   req_valid/req_ready/req_a/req_b/req_op : per-requester issue ports
//   rsp_valid/rsp_ready/rsp_id/rsp_out     : tagged response channel
//   rsp_n/rsp_v/rsp_z                      : response flags
//   master : requesters + response consumer;  slave : the arbiter
interface fixed_addsub_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ-1:0]                 req_ready;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_a;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]                 req_op;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [DATA_WIDTH-1:0] rsp_out;
  logic                  rsp_n;
  logic                  rsp_v;
  logic                  rsp_z;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_out, rsp_n, rsp_v, rsp_z
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_out, rsp_n, rsp_v, rsp_z
  );

endinterface

// File: rtl/Add_Sub_FixedPoint.sv
// rtl/Add_Sub_FixedPoint.sv - two's-complement fixed-point adder/subtractor with N/V/Z
//   A, B : operands;  op : 0 = A+B, 1 = A-B
//   Out  : wrapped result;  N/V/Z : negative, signed overflow, zero
module Add_Sub_FixedPoint #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             op,
  output logic [WIDTH-1:0] Out,
  output logic             N,
  output logic             V,
  output logic             Z
);

  logic sa, sb, so;

  assign Out = op ? (A - B) : (A + B);
  assign sa  = A[WIDTH-1];
  assign sb  = B[WIDTH-1];
  assign so  = Out[WIDTH-1];

  // Overflow: operands effectively share a sign but the result sign differs.
  assign V = op ? ((sa != sb) && (so != sa)) : ((sa == sb) && (so != sa));
  assign N = so;
  assign Z = (Out == '0);

endmodule

// File: rtl/fixed_addsub_arbiter_rr_pick.sv
// rtl/fixed_addsub_arbiter_rr_pick.sv - combinational round-robin picker
//   req : request vector;  ptr : highest-priority index
//   gnt : one-hot grant;   idx : granted index;  any : some request present
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W:0] cand;

  // Walk indices ptr, ptr+1, ... modulo N; the first set request wins.
  // ptr is always < N, so one conditional subtraction performs the wrap.
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int i = 0; i < N; i++) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(N)) begin
        cand = cand - (IDX_W+1)'(N);
      end
      if (!any && req[cand[IDX_W-1:0]]) begin
        any = 1'b1;
        idx = cand[IDX_W-1:0];
      end
    end
  end

  assign gnt = any ? (N'(1) << idx) : '0;

endmodule

// File: rtl/fixed_addsub_arbiter.sv
// rtl/fixed_addsub_arbiter.sv - round-robin sharing of one Q8.8 add/sub unit
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of fixed_addsub_arbiter_if (requests in, tagged response out)
module fixed_addsub_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REQ    = 4,
  parameter int SATURATE   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fixed_addsub_arbiter_if.slave bus
);
  import fixed_point_pkg::*;

  localparam int ID_W = $clog2(NUM_REQ);
  localparam int MSB  = DATA_WIDTH - 1;

  localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  arb_state_t state_q, state_d;

  logic [ID_W-1:0]       ptr_q;
  logic [ID_W-1:0]       g_q;
  logic [DATA_WIDTH-1:0] a_q, b_q;
  logic                  op_q;

  logic [DATA_WIDTH-1:0] rsp_out_q;
  logic [ID_W-1:0]       rsp_id_q;
  fx_flags_t             rsp_flags_q;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [ID_W-1:0]    pick_idx;
  logic [ID_W-1:0]    pick_ptr;
  logic               pick_any;

  logic [ID_W-1:0] ptr_after_g;
  logic            accept;
  logic            arb_en;
  logic            grant;

  logic [DATA_WIDTH-1:0] add_out;
  logic                  add_n, add_v, add_z;
  logic [DATA_WIDTH-1:0] res_out;
  fx_flags_t             res_flags;

  assign ptr_after_g = (g_q == ID_W'(NUM_REQ - 1)) ? '0 : g_q + ID_W'(1);
  assign accept      = (state_q == DONE) && bus.rsp_ready;

  // Arbitration is live in IDLE and in the DONE cycle that retires the
  // response; the retiring cycle already uses the advanced pointer so the
  // next grant lands back-to-back. Held in reset, nothing may be granted.
  assign arb_en   = rst_n && ((state_q == IDLE) || accept);
  assign pick_ptr = accept ? ptr_after_g : ptr_q;
  assign grant    = arb_en && pick_any;

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (ID_W)
  ) u_pick (
    .req (bus.req_valid),
    .ptr (pick_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign bus.req_ready = arb_en ? pick_gnt : '0;

  Add_Sub_FixedPoint #(
    .WIDTH (DATA_WIDTH)
  ) u_addsub (
    .A   (a_q),
    .B   (b_q),
    .op  (op_q),
    .Out (add_out),
    .N   (add_n),
    .V   (add_v),
    .Z   (add_z)
  );

  // Clamp toward the sign of A: on overflow A and the true result agree in sign.
  always_comb begin
    res_out     = add_out;
    res_flags.n = add_n;
    res_flags.v = add_v;
    res_flags.z = add_z;
    if ((SATURATE != 0) && add_v) begin
      res_out     = a_q[MSB] ? SAT_MIN : SAT_MAX;
      res_flags.n = res_out[MSB];
      res_flags.z = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (pick_any) state_d = EXEC;
      EXEC: state_d = DONE;
      DONE: if (bus.rsp_ready) state_d = pick_any ? EXEC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      g_q         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= 1'b0;
      rsp_out_q   <= '0;
      rsp_id_q    <= '0;
      rsp_flags_q <= '0;
    end else begin
      // The pointer moves only when a response is consumed.
      if (accept) begin
        ptr_q <= ptr_after_g;
      end
      if (grant) begin
        g_q  <= pick_idx;
        a_q  <= bus.req_a[pick_idx];
        b_q  <= bus.req_b[pick_idx];
        op_q <= bus.req_op[pick_idx];
      end
      if (state_q == EXEC) begin
        rsp_out_q   <= res_out;
        rsp_id_q    <= g_q;
        rsp_flags_q <= res_flags;
      end
    end
  end

  assign bus.rsp_valid = (state_q == DONE);
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_out   = rsp_out_q;
  assign bus.rsp_n     = rsp_flags_q.n;
  assign bus.rsp_v     = rsp_flags_q.v;
  assign bus.rsp_z     = rsp_flags_q.z;

endmodule

// File: tb/tb_fixed_addsub_arbiter.sv
// tb/tb_fixed_addsub_arbiter.sv - self-checking bench for fixed_addsub_arbiter
module tb_fixed_addsub_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  fixed_addsub_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(16)) bus ();

  fixed_addsub_arbiter #(
    .DATA_WIDTH (16),
    .NUM_REQ    (4),
    .SATURATE   (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          id;
    logic [15:0] a;
    logic [15:0] b;
    logic        op;
    logic [15:0] out;
    logic [2:0]  nvz;
  } vec_t;

  vec_t vecs [8];
  int   exp_g [5] = '{0, 1, 2, 3, 0};
  int   remaining [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_edge();
    @(posedge clk);
    #1;
  endtask

  // One isolated operation from IDLE: grant, EXEC, response, accept.
  task automatic run_vec(input vec_t v);
    logic [3:0] onehot;
    onehot = 4'b0001 << v.id;
    bus.req_valid       = '0;
    bus.req_a[v.id]     = v.a;
    bus.req_b[v.id]     = v.b;
    bus.req_op[v.id]    = v.op;
    bus.req_valid[v.id] = 1'b1;
    @(negedge clk);
    chk("vec_grant", 32'(bus.req_ready), 32'(onehot));
    wait_edge();
    bus.req_valid[v.id] = 1'b0;
    @(negedge clk);
    chk("vec_exec_valid", 32'(bus.rsp_valid), 32'd0);
    wait_edge();
    @(negedge clk);
    chk("vec_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("vec_rsp_id", 32'(bus.rsp_id), 32'(v.id));
    chk("vec_rsp_out", 32'(bus.rsp_out), 32'(v.out));
    chk("vec_rsp_nvz", 32'({bus.rsp_n, bus.rsp_v, bus.rsp_z}), 32'(v.nvz));
    bus.rsp_ready = 1'b1;
    wait_edge();
    bus.rsp_ready = 1'b0;
  endtask

  // A pending request must stay up until it is granted.
  logic [3:0] pend;
  always @(posedge clk) begin
    if (!rst_n) begin
      pend <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (pend[i] && !bus.req_valid[i]) begin
          errors++;
          $display("FAIL withdraw: requester %0d dropped req_valid before req_ready", i);
        end
      end
      pend <= bus.req_valid & ~bus.req_ready;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] hs;
    logic [3:0] exp_rdy;
    int         gi;

    checks = 0;
    errors = 0;

    vecs[0] = '{id: 2, a: 16'h3240, b: 16'h1920, op: 1'b0, out: 16'h4B60, nvz: 3'b000};
    vecs[1] = '{id: 1, a: 16'h7F00, b: 16'h0100, op: 1'b0, out: 16'h7FFF, nvz: 3'b010};
    vecs[2] = '{id: 0, a: 16'h8000, b: 16'h0100, op: 1'b1, out: 16'h8000, nvz: 3'b110};
    vecs[3] = '{id: 3, a: 16'h0240, b: 16'h0240, op: 1'b1, out: 16'h0000, nvz: 3'b001};
    vecs[4] = '{id: 0, a: 16'h0100, b: 16'h0300, op: 1'b1, out: 16'hFE00, nvz: 3'b100};
    vecs[5] = '{id: 1, a: 16'h8000, b: 16'h8000, op: 1'b0, out: 16'h8000, nvz: 3'b110};
    vecs[6] = '{id: 2, a: 16'h7FFF, b: 16'hFFFF, op: 1'b1, out: 16'h7FFF, nvz: 3'b010};
    vecs[7] = '{id: 3, a: 16'hFF00, b: 16'h0100, op: 1'b0, out: 16'h0000, nvz: 3'b001};

    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_op    = '0;
    bus.rsp_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
    chk("rst_rsp_out", 32'(bus.rsp_out), 32'd0);
    chk("rst_rsp_nvz", 32'({bus.rsp_n, bus.rsp_v, bus.rsp_z}), 32'd0);
    wait_edge();
    rst_n = 1'b1;

    // Table-driven single operations (first one right after reset release)
    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i]);
    end

    // Round-robin with all four requesters and rsp_ready held high; ptr is 0 here
    remaining = '{2, 1, 1, 1};
    for (int r = 0; r < 4; r++) begin
      bus.req_a[r]  = 16'(r * 256);
      bus.req_b[r]  = 16'h0010;
      bus.req_op[r] = 1'b0;
    end
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'hF;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      hs = bus.req_valid & bus.req_ready;
      if (k % 2 == 0) begin
        exp_rdy = (k <= 8) ? (4'b0001 << exp_g[k/2]) : 4'b0000;
        chk("rr_grant", 32'(bus.req_ready), 32'(exp_rdy));
        if (k >= 2) begin
          gi = exp_g[k/2 - 1];
          chk("rr_rsp_valid", 32'(bus.rsp_valid), 32'd1);
          chk("rr_rsp_id", 32'(bus.rsp_id), 32'(gi));
          chk("rr_rsp_out", 32'(bus.rsp_out), 32'(gi * 256 + 16));
        end
      end else begin
        chk("rr_gap_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rr_gap_ready", 32'(bus.req_ready), 32'd0);
      end
      wait_edge();
      for (int r = 0; r < 4; r++) begin
        if (hs[r]) begin
          remaining[r]--;
          if (remaining[r] == 0) bus.req_valid[r] = 1'b0;
        end
      end
    end
    bus.rsp_ready = 1'b0;

    // Backpressure: ptr is 1; requester 2 waits behind a stalled response
    bus.req_a[1]  = 16'h0100; bus.req_b[1] = 16'h0100; bus.req_op[1] = 1'b0;
    bus.req_a[2]  = 16'h0500; bus.req_b[2] = 16'h0180; bus.req_op[2] = 1'b1;
    bus.req_valid = 4'b0110;
    @(negedge clk);
    chk("bp_grant", 32'(bus.req_ready), 32'b0010);
    wait_edge();
    bus.req_valid[1] = 1'b0;
    @(negedge clk);
    chk("bp_exec_valid", 32'(bus.rsp_valid), 32'd0);
    wait_edge();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_hold_id", 32'(bus.rsp_id), 32'd1);
      chk("bp_hold_out", 32'(bus.rsp_out), 32'h0200);
      chk("bp_hold_nvz", 32'({bus.rsp_n, bus.rsp_v, bus.rsp_z}), 32'd0);
      chk("bp_hold_ready", 32'(bus.req_ready), 32'd0);
      wait_edge();
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", 32'(bus.rsp_valid), 32'd1);
    chk("bp_release_grant", 32'(bus.req_ready), 32'b0100);
    wait_edge();
    bus.req_valid[2] = 1'b0;
    bus.rsp_ready    = 1'b0;
    @(negedge clk);
    chk("bp_exec2_valid", 32'(bus.rsp_valid), 32'd0);
    wait_edge();
    @(negedge clk);
    chk("bp_rsp2_valid", 32'(bus.rsp_valid), 32'd1);
    chk("bp_rsp2_id", 32'(bus.rsp_id), 32'd2);
    chk("bp_rsp2_out", 32'(bus.rsp_out), 32'h0380);
    bus.rsp_ready = 1'b1;
    wait_edge();
    bus.rsp_ready = 1'b0;

    // Reset during EXEC: ptr is 3, so requester 3 wins before reset
    bus.req_a[1]  = 16'h0010; bus.req_b[1] = 16'h0020; bus.req_op[1] = 1'b1;
    bus.req_a[3]  = 16'h1000; bus.req_b[3] = 16'h0800; bus.req_op[3] = 1'b0;
    bus.req_valid = 4'b1010;
    @(negedge clk);
    chk("rm_grant_pre", 32'(bus.req_ready), 32'b1000);
    wait_edge();
    bus.req_valid[3] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rm_rst_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rm_rst_ready", 32'(bus.req_ready), 32'd0);
    wait_edge();
    rst_n = 1'b1;
    bus.req_valid[3] = 1'b1;
    @(negedge clk);
    chk("rm_grant_post", 32'(bus.req_ready), 32'b0010);
    chk("rm_no_rsp0", 32'(bus.rsp_valid), 32'd0);
    wait_edge();
    bus.req_valid[1] = 1'b0;
    @(negedge clk);
    chk("rm_no_rsp1", 32'(bus.rsp_valid), 32'd0);
    wait_edge();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("rm_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("rm_rsp_id", 32'(bus.rsp_id), 32'd1);
    chk("rm_rsp_out", 32'(bus.rsp_out), 32'hFFF0);
    chk("rm_rsp_nvz", 32'({bus.rsp_n, bus.rsp_v, bus.rsp_z}), 32'b100);
    chk("rm_b2b_grant", 32'(bus.req_ready), 32'b1000);
    wait_edge();
    bus.req_valid[3] = 1'b0;
    bus.rsp_ready    = 1'b0;
    @(negedge clk);
    chk("rm_exec_valid", 32'(bus.rsp_valid), 32'd0);
    wait_edge();
    @(negedge clk);
    chk("rm_rsp3_valid", 32'(bus.rsp_valid), 32'd1);
    chk("rm_rsp3_id", 32'(bus.rsp_id), 32'd3);
    chk("rm_rsp3_out", 32'(bus.rsp_out), 32'h1800);
    bus.rsp_ready = 1'b1;
    wait_edge();
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    chk("end_idle_valid", 32'(bus.rsp_valid), 32'd0);
    chk("end_idle_ready", 32'(bus.req_ready), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
